// File: rtl/ixu_pkg.sv
// Shared types and constants for the IXU issue path: ALU op encoding,
// RV32I opcode/funct7 constants and the decoded packet handed to the ALU slot.
package ixu_pkg;

    localparam int PKT_XLEN = 32;
    localparam int PKT_RD_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_XOR  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_AND  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_BAD  = 4'hF
    } alu_op_t;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;

    typedef struct packed {
        alu_op_t               op;
        logic [PKT_XLEN-1:0]   x;
        logic [PKT_XLEN-1:0]   y;
        logic [PKT_RD_W-1:0]   rd;
    } issue_pkt_t;

    // funct3 to op for the base (funct7 = 0) encodings shared by OP and OP-IMM
    function automatic alu_op_t f3_to_op(input logic [2:0] f3);
        alu_op_t op;
        case (f3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ixu_issue_decode.sv
// Purely combinational RV32I OP / OP-IMM decoder producing the ALU packet.
// Anything unsupported yields is_illegal=1 and a packet of {ALU_BAD,0,0,0}.
module ixu_issue_decode
    import ixu_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    output issue_pkt_t  pkt,
    output logic        is_illegal
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       is_shift;
    logic       unused_rs_idx;

    assign opc      = instr[6:0];
    assign f3       = instr[14:12];
    assign f7       = instr[31:25];
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);
    // Register indices were already consumed by regread; only values matter here.
    assign unused_rs_idx = ^instr[19:15];

    // Decode opcode/funct fields into op and operand selection
    always_comb begin
        pkt        = '0;
        is_illegal = 1'b0;
        case (opc)
            OPC_OP: begin
                pkt.x = rs1_val;
                pkt.y = is_shift ? {27'b0, rs2_val[4:0]} : rs2_val;
                if (f7 == F7_BASE)                        pkt.op = f3_to_op(f3);
                else if (f7 == F7_ALT && f3 == 3'b000)    pkt.op = ALU_SUB;
                else if (f7 == F7_ALT && f3 == 3'b101)    pkt.op = ALU_SRA;
                else                                      is_illegal = 1'b1;
            end
            OPC_OPIMM: begin
                pkt.x = rs1_val;
                if (is_shift) begin
                    pkt.y = {27'b0, instr[24:20]};
                    if (f7 == F7_BASE)                     pkt.op = f3_to_op(f3);
                    else if (f7 == F7_ALT && f3 == 3'b101) pkt.op = ALU_SRA;
                    else                                   is_illegal = 1'b1;
                end else begin
                    // SLTIU also uses the sign-extended immediate; the ALU compares unsigned
                    pkt.y  = {{20{instr[31]}}, instr[31:20]};
                    pkt.op = f3_to_op(f3);
                end
            end
            default: is_illegal = 1'b1;
        endcase
        if (is_illegal) begin
            pkt.op = ALU_BAD;
            pkt.x  = '0;
            pkt.y  = '0;
            pkt.rd = '0;
        end else begin
            pkt.rd = instr[11:7];
        end
    end

endmodule

// File: rtl/ixu_issue.sv
// IXU issue stage: decodes RV32I integer ops into a 2-entry skid buffer and
// presents the head entry to the ALU slot.
// Handshake: a transfer occurs at the rising edge when valid and ready are both
// high; valid never waits for ready, and in_ready is a pure register output.
// Optional macro IXU_ILLEGAL_TRAP_EN: illegal instructions are consumed without
// being enqueued and pulse `illegal`; otherwise they flow through as ALU_BAD.
module ixu_issue
    import ixu_pkg::*;
#(
    parameter int RD_W = 5,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_op,
    output logic [XLEN-1:0] out_x,
    output logic [XLEN-1:0] out_y,
    output logic [RD_W-1:0] out_rd,
    output logic            illegal
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_t;

    occ_t       state_q, state_nxt;
    issue_pkt_t head_q, tail_q;
    issue_pkt_t dec_pkt;
    logic       dec_illegal;
    logic       in_fire, acc, drn, ill_fire;

    ixu_issue_decode u_decode (
        .instr      (in_instr),
        .rs1_val    (in_rs1_val),
        .rs2_val    (in_rs2_val),
        .pkt        (dec_pkt),
        .is_illegal (dec_illegal)
    );

    assign in_fire = in_valid && in_ready && !flush;
    assign drn     = out_valid && out_ready;

`ifdef IXU_ILLEGAL_TRAP_EN
    assign acc      = in_fire && !dec_illegal;
    assign ill_fire = in_fire && dec_illegal;
`else
    logic unused_dec_illegal;
    assign unused_dec_illegal = dec_illegal;
    assign acc      = in_fire;
    assign ill_fire = 1'b0;
`endif

    // Occupancy next-state; flush empties the buffer regardless of traffic
    always_comb begin
        state_nxt = state_q;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (acc) state_nxt = ST_ONE;
                ST_ONE: begin
                    if (acc && !drn)      state_nxt = ST_FULL;
                    else if (drn && !acc) state_nxt = ST_EMPTY;
                end
                ST_FULL:  if (drn) state_nxt = ST_ONE;
                default:  state_nxt = ST_EMPTY;
            endcase
        end
    end

    // State register plus registered in_ready and illegal pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            in_ready <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            in_ready <= (state_nxt != ST_FULL);
            illegal  <= ill_fire;
        end
    end

    // Entry storage: head feeds the outputs, tail only holds the skid entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else if (!flush) begin
            case (state_q)
                ST_EMPTY: if (acc) head_q <= dec_pkt;
                ST_ONE: begin
                    if (acc && drn) head_q <= dec_pkt;
                    else if (acc)   tail_q <= dec_pkt;
                end
                ST_FULL:  if (drn) head_q <= tail_q;
                default: ;
            endcase
        end
    end

    assign out_valid = (state_q != ST_EMPTY);
    assign out_op    = head_q.op;
    assign out_x     = head_q.x;
    assign out_y     = head_q.y;
    assign out_rd    = head_q.rd;

endmodule

// File: tb/tb_ixu_issue.sv
// Bench for ixu_issue: directed vector table, hand-written multi-cycle
// sequences (back-pressure, flush, async reset) and a randomized phase checked
// against a queue-based reference model of the issue stage.
module tb_ixu_issue;

`ifdef IXU_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk, rst, flush;
    logic        in_valid, in_ready, out_valid, out_ready, illegal;
    logic [31:0] in_instr, in_rs1_val, in_rs2_val, out_x, out_y;
    logic [3:0]  out_op;
    logic [4:0]  out_rd;

    int n_vec  = 0;
    int n_miss = 0;

    // {op[3:0], x[31:0], y[31:0], rd[4:0]}
    logic [72:0] exp_q[$];
    bit          ill_pend;
    int          base_op[8];

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [3:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [4:0]  rd;
        bit          bad;
    } vec_t;

    vec_t vecs[13];

    ixu_issue dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_rs1_val (in_rs1_val),
        .in_rs2_val (in_rs2_val),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_op     (out_op),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_rd     (out_rd),
        .illegal    (illegal)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference decode straight from the instruction-set rules
    function automatic logic [72:0] ref_decode(input logic [31:0] instr, input logic [31:0] rs1,
                                                input logic [31:0] rs2, output bit bad);
        int          f3, f7, op;
        logic [31:0] y;
        bit          shift;
        f3    = int'(instr[14:12]);
        f7    = int'(instr[31:25]);
        shift = (f3 == 1) || (f3 == 5);
        bad   = 1'b0;
        op    = 0;
        y     = 0;
        if (instr[6:0] == 7'h33) begin
            y = shift ? (rs2 % 32) : rs2;
            if (f7 == 0)                 op = base_op[f3];
            else if (f7 == 32 && f3 == 0) op = 1;
            else if (f7 == 32 && f3 == 5) op = 7;
            else                          bad = 1'b1;
        end else if (instr[6:0] == 7'h13) begin
            if (shift) begin
                y = 32'(instr[24:20]);
                if (f7 == 0)                  op = base_op[f3];
                else if (f7 == 32 && f3 == 5) op = 7;
                else                          bad = 1'b1;
            end else begin
                y  = 32'($signed(instr[31:20]));
                op = base_op[f3];
            end
        end else begin
            bad = 1'b1;
        end
        if (bad) return {4'hF, 32'h0, 32'h0, 5'h0};
        return {op[3:0], rs1, y, instr[11:7]};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int          w, k;
        r = $urandom;
        w = $urandom_range(0, 9);
        k = $urandom_range(0, 3);
        if (k < 2)       r[31:25] = 7'h00;
        else if (k == 2) r[31:25] = 7'h20;
        if (w < 5)       r[6:0] = 7'h33;
        else if (w < 9)  r[6:0] = 7'h13;
        return r;
    endfunction

    // One cycle: drive at negedge, check against the model, advance the model
    task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] r1,
                        input logic [31:0] r2, input bit ordy, input bit fl);
        logic [72:0] e;
        bit          bad, exp_rdy, fire_in, fire_out;
        @(negedge clk);
        in_valid   = v;
        in_instr   = ins;
        in_rs1_val = r1;
        in_rs2_val = r2;
        out_ready  = ordy;
        flush      = fl;
        #1;
        exp_rdy = (exp_q.size() < 2);
        check("in_ready", in_ready, exp_rdy);
        check("out_valid", out_valid, exp_q.size() != 0);
        check("illegal", illegal, ill_pend);
        if (exp_q.size() != 0) begin
            e = exp_q[0];
            check("head_op", out_op, e[72:69]);
            check("head_x", out_x, e[68:37]);
            check("head_y", out_y, e[36:5]);
            check("head_rd", out_rd, e[4:0]);
        end
        fire_in  = v && exp_rdy && !fl;
        fire_out = (exp_q.size() != 0) && ordy;
        ill_pend = 1'b0;
        if (fl) begin
            exp_q.delete();
        end else begin
            if (fire_out) void'(exp_q.pop_front());
            if (fire_in) begin
                e = ref_decode(ins, r1, r2, bad);
                if (bad && TRAP) ill_pend = 1'b1;
                else             exp_q.push_back(e);
            end
        end
        @(posedge clk);
    endtask

    localparam logic [31:0] ADD_I = 32'h002081B3;

    initial begin
        bit exp_v;
        base_op = '{0, 5, 8, 9, 2, 6, 3, 4};
        vecs[0]  = '{32'h002081B3, 32'd5,        32'd7,        4'd0, 32'd5,        32'd7,        5'd3,  1'b0};
        vecs[1]  = '{32'h41F0D213, 32'h80000000, 32'h55,       4'd7, 32'h80000000, 32'd31,       5'd4,  1'b0};
        vecs[2]  = '{32'hFFF0B093, 32'h10,       32'h0,        4'd9, 32'h10,       32'hFFFFFFFF, 5'd1,  1'b0};
        vecs[3]  = '{32'h002092B3, 32'hA5,       32'h123,      4'd5, 32'hA5,       32'h3,        5'd5,  1'b0};
        vecs[4]  = '{32'h40208333, 32'd100,      32'd30,       4'd1, 32'd100,      32'd30,       5'd6,  1'b0};
        vecs[5]  = '{32'hFFB08393, 32'd42,       32'h0,        4'd0, 32'd42,       32'hFFFFFFFB, 5'd7,  1'b0};
        vecs[6]  = '{32'h7FF0F413, 32'hFFFF,     32'h0,        4'd4, 32'hFFFF,     32'h7FF,      5'd8,  1'b0};
        vecs[7]  = '{32'h0020D4B3, 32'hF0,       32'hFFFFFFE3, 4'd6, 32'hF0,       32'h3,        5'd9,  1'b0};
        vecs[8]  = '{32'h8000A513, 32'hFFFFFFFF, 32'h0,        4'd8, 32'hFFFFFFFF, 32'hFFFFF800, 5'd10, 1'b0};
        vecs[9]  = '{32'h0020E5B3, 32'h0F,       32'hF0,       4'd3, 32'h0F,       32'hF0,       5'd11, 1'b0};
        vecs[10] = '{32'h000010B7, 32'h11,       32'h22,       4'hF, 32'h0,        32'h0,        5'd0,  1'b1};
        vecs[11] = '{32'h4020C1B3, 32'h33,       32'h44,       4'hF, 32'h0,        32'h0,        5'd0,  1'b1};
        vecs[12] = '{32'h40109093, 32'h55,       32'h66,       4'hF, 32'h0,        32'h0,        5'd0,  1'b1};

        // Reset state
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_rs1_val = '0; in_rs2_val = '0;
        ill_pend = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_op", out_op, 0);
        check("rst_x", out_x, 0);
        check("rst_y", out_y, 0);
        check("rst_rd", out_rd, 0);
        check("rst_illegal", illegal, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);

        // Directed decode table, one instruction at a time with out_ready=1
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            in_valid   = 1'b1;
            in_instr   = vecs[i].instr;
            in_rs1_val = vecs[i].rs1;
            in_rs2_val = vecs[i].rs2;
            out_ready  = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            exp_v = !(TRAP && vecs[i].bad);
            check($sformatf("tbl%0d_valid", i), out_valid, exp_v);
            check($sformatf("tbl%0d_illegal", i), illegal, TRAP && vecs[i].bad);
            if (exp_v) begin
                check($sformatf("tbl%0d_op", i), out_op, vecs[i].op);
                check($sformatf("tbl%0d_x", i), out_x, vecs[i].x);
                check($sformatf("tbl%0d_y", i), out_y, vecs[i].y);
                check($sformatf("tbl%0d_rd", i), out_rd, vecs[i].rd);
            end
            @(posedge clk);
        end
        @(negedge clk);
        #1;
        check("tbl_drained", out_valid, 0);

        // Back-pressure: three offered, two held, release drains in order
        step(1, ADD_I, 32'd1, 32'd0, 0, 0);
        step(1, ADD_I, 32'd2, 32'd0, 0, 0);
        step(1, ADD_I, 32'd3, 32'd0, 0, 0);
        check("bp_third_blocked", in_ready, 0);
        step(1, ADD_I, 32'd3, 32'd0, 1, 0);
        step(1, ADD_I, 32'd3, 32'd0, 1, 0);
        step(0, ADD_I, 32'd0, 32'd0, 1, 0);
        step(0, ADD_I, 32'd0, 32'd0, 1, 0);

        // Flush with the buffer full and a live input
        step(1, ADD_I, 32'd10, 32'd0, 0, 0);
        step(1, ADD_I, 32'd11, 32'd0, 0, 0);
        step(1, ADD_I, 32'd12, 32'd0, 0, 1);
        step(0, ADD_I, 32'd0, 32'd0, 1, 0);
        step(0, ADD_I, 32'd0, 32'd0, 1, 0);

        // Unsupported opcode through the handshake path
        step(1, 32'h000010B7, 32'd9, 32'd9, 1, 0);
        step(0, ADD_I, 32'd0, 32'd0, 1, 0);
        step(0, ADD_I, 32'd0, 32'd0, 1, 0);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 9) < 7, rand_instr(), $urandom, $urandom,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);
        end

        // Asynchronous reset mid-stream clears outputs without a clock edge
        step(1, ADD_I, 32'd20, 32'd5, 0, 0);
        step(1, ADD_I, 32'd21, 32'd6, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_in_ready", in_ready, 0);
        check("arst_op", out_op, 0);
        check("arst_x", out_x, 0);
        check("arst_y", out_y, 0);
        check("arst_rd", out_rd, 0);
        exp_q.delete();
        ill_pend = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        step(1, ADD_I, 32'd30, 32'd1, 1, 0);
        step(0, ADD_I, 32'd0, 32'd0, 1, 0);
        step(0, ADD_I, 32'd0, 32'd0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
